// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined XLEN-generic shifter/rotator with valid/ready flow control, tag and flush
// Every op is reduced to a right-rotate plus a fill mask; rotate levels are spread across the stages.
module shift_pipe #(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int L     = $clog2(XLEN);
  localparam int P     = PIPE_STAGES;
  localparam int BASE  = L / P;
  localparam int EXTRA = L % P;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  mask;
    logic [L-1:0]     rot;
    logic             fill;
    logic             is_w;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } pay_t;

  pay_t         dec;
  pay_t         pay_d [P];
  pay_t         pay_q [P];
  logic [P-1:0] vld_q;
  logic [P-1:0] vld_d;
  logic [P-1:0] take;
  logic [P:0]   rdy;
  logic         is_w;
  logic         left;
  logic [L-1:0] sh;
  logic [L-1:0] sh_neg;

  // Left shifts become right rotates by the negated amount; W ops rotate a doubled low word.
  always_comb begin
    dec      = '0;
    is_w     = (XLEN == 64) && (in_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9});
    left     = in_op inside {4'd2, 4'd4, 4'd7, 4'd9};
    sh       = is_w ? L'(in_src2[4:0]) : in_src2[L-1:0];
    sh_neg   = ~sh + L'(1);
    dec.rot  = !left ? sh : (is_w ? L'(sh_neg[4:0]) : sh_neg);
    dec.data = is_w ? {(XLEN/32){in_src1[31:0]}} : in_src1;
    dec.is_w = is_w;
    dec.tag  = in_tag;
    dec.fill = (in_op == 4'd0) ? in_src1[31] : ((in_op == 4'd5) ? in_src1[XLEN-1] : 1'b0);
    case (in_op)
      4'd0, 4'd1, 4'd3, 4'd5: dec.mask = is_w ? XLEN'(32'hFFFF_FFFF >> sh) : {XLEN{1'b1}} >> sh;
      4'd2, 4'd4:             dec.mask = is_w ? XLEN'(32'hFFFF_FFFF << sh) : {XLEN{1'b1}} << sh;
      4'd6, 4'd7, 4'd8, 4'd9: dec.mask = '1;
      default:                dec.zero = 1'b1;
    endcase
  end

  for (genvar s = 0; s < P; s++) begin : g_stage
    localparam int LO = s * BASE + ((s < EXTRA) ? s : EXTRA);
    localparam int N  = BASE + ((s < EXTRA) ? 1 : 0);
    pay_t            src;
    pay_t            nxt;
    logic [XLEN-1:0] rot_v;

    if (s == 0) begin : g_src0
      assign src = dec;
    end else begin : g_srcn
      assign src = pay_q[s-1];
    end

    always_comb begin
      rot_v = src.data;
      for (int k = LO; k < LO + N; k++) begin
        if (src.rot[k]) rot_v = (rot_v >> (1 << k)) | (rot_v << (XLEN - (1 << k)));
      end
    end

    if (s == P - 1) begin : g_last
      logic [XLEN-1:0] fin;
      logic [XLEN-1:0] res;
      assign fin = (rot_v & src.mask) | ({XLEN{src.fill}} & ~src.mask);
      always_comb begin
        res = fin;
        if (src.is_w) res = XLEN'($signed(fin[31:0]));
        if (src.zero) res = '0;
        nxt      = src;
        nxt.data = res;
      end
    end else begin : g_mid
      always_comb begin
        nxt      = src;
        nxt.data = rot_v;
      end
    end

    assign pay_d[s] = nxt;
  end

  always_comb begin
    rdy    = '0;
    rdy[P] = out_ready;
    for (int s = P - 1; s >= 0; s--) rdy[s] = !vld_q[s] || rdy[s+1];
    in_ready = rdy[0] && !flush && !rst;
    take     = '0;
    take[0]  = in_valid && in_ready;
    for (int s = 1; s < P; s++) take[s] = vld_q[s-1];
    vld_d = '0;
    for (int s = 0; s < P; s++) vld_d[s] = flush ? 1'b0 : (rdy[s] ? take[s] : vld_q[s]);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
    for (int s = 0; s < P; s++) begin
      if (rdy[s] && take[s]) pay_q[s] <= pay_d[s];
    end
    if (rst) pay_q[P-1] <= '0;
  end

  assign out_valid  = vld_q[P-1] && !rst;
  assign out_result = rst ? '0 : pay_q[P-1].data;
  assign out_tag    = rst ? '0 : pay_q[P-1].tag;

  logic unused_ok;
  assign unused_ok = ^{in_src2, pay_q[P-1]};
endmodule
